// File: rtl/sine_mon_pkg.sv
// sine_mon_pkg: shared sample/state types and default thresholds for the sine period monitor
package sine_mon_pkg;
  typedef logic signed [15:0] sample_t;
  typedef enum logic [1:0] {S_IDLE, S_NEG, S_POS} zc_state_t;
  localparam int HYST_DEF = 256;
  localparam int TOL_DEF = 2;
endpackage

// File: rtl/sine_zc_detect.sv
// sine_zc_detect: hysteresis zero-crossing FSM with a combinational rising-crossing pulse
module sine_zc_detect
  import sine_mon_pkg::*;
#(
  parameter int DW = 16,
  parameter int HYST = HYST_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] d,
  input  logic                 d_valid,
  input  logic                 clear,
  output zc_state_t            state,
  output logic                 evt
);
  localparam logic signed [DW-1:0] HI = DW'(HYST);
  localparam logic signed [DW-1:0] LO = -HI;
  logic below, above;
  assign below = d < LO;
  assign above = d >= HI;
  assign evt = d_valid && state == S_NEG && above;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else if (clear) state <= S_IDLE;
    else if (d_valid) state <= below ? S_NEG : evt ? S_POS : state;
endmodule

// File: rtl/sine_period_monitor.sv
// sine_period_monitor: period/lock/timeout monitor for a sine stream; SINE_MON_PEAK_EN adds per-period peak/trough
module sine_period_monitor
  import sine_mon_pkg::*;
#(
  parameter int DW = 16,
  parameter int PW = 16,
  parameter int HYST = HYST_DEF,
  parameter int TOL = TOL_DEF,
  parameter int LOCK_N = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] d,
  input  logic                 d_valid,
  output logic [PW-1:0]        period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 timeout,
  output logic signed [DW-1:0] peak,
  output logic signed [DW-1:0] trough
);
  localparam int SW = $clog2(LOCK_N + 1);
  localparam logic [PW-1:0] CMAX = '1;
  localparam logic [PW-1:0] TOLV = PW'(TOL);
  localparam logic [SW-1:0] LOCKV = SW'(LOCK_N);
  zc_state_t state;
  logic evt, sat, armed, stable;
  logic [PW-1:0] cnt, diff;
  logic [SW-1:0] sc, sc_nx;
  sine_zc_detect #(.DW(DW), .HYST(HYST)) u_zc (
    .clk(clk), .reset_n(reset_n), .d(d), .d_valid(d_valid),
    .clear(sat), .state(state), .evt(evt)
  );
  // a crossing on the saturating sample wins; an already-reported timeout cannot retrigger on the frozen counter
  assign sat = d_valid && !evt && !timeout && cnt == CMAX && state != S_IDLE;
  assign diff = cnt >= period ? cnt - period : period - cnt;
  assign stable = diff <= TOLV;
  assign sc_nx = sc == LOCKV ? sc : sc + SW'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      armed <= 1'b0;
      sc <= '0;
      period <= '0;
      period_valid <= 1'b0;
      locked <= 1'b0;
      timeout <= 1'b0;
    end else begin
      period_valid <= evt && armed;
      if (evt) begin
        cnt <= PW'(1);
        armed <= 1'b1;
        if (armed) begin
          period <= cnt;
          timeout <= 1'b0;
          sc <= stable ? sc_nx : '0;
          locked <= stable && sc_nx == LOCKV;
        end
      end else if (sat) begin
        timeout <= 1'b1;
        locked <= 1'b0;
        sc <= '0;
        armed <= 1'b0;
      end else if (d_valid && cnt != CMAX) cnt <= cnt + PW'(1);
    end
`ifdef SINE_MON_PEAK_EN
  logic signed [DW-1:0] mx, mn;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mx <= '0;
      mn <= '0;
      peak <= '0;
      trough <= '0;
    end else if (evt) begin
      if (armed) begin
        peak <= mx;
        trough <= mn;
      end
      mx <= d;
      mn <= d;
    end else if (d_valid) begin
      mx <= d > mx ? d : mx;
      mn <= d < mn ? d : mn;
    end
`else
  assign peak = '0;
  assign trough = '0;
`endif
endmodule

// File: tb/tb_sine_period_monitor.sv
// tb_sine_period_monitor: scoreboard bench for sine_period_monitor at PW=8; define SINE_MON_PEAK_EN to check peak/trough
module tb_sine_period_monitor;
  import sine_mon_pkg::*;
  typedef struct { int per; int lk; int to; int pk; int tr; int cyc; } exp_t;
  logic clk = 1'b0, reset_n, d_valid = 1'b0, period_valid, locked, timeout;
  sample_t d = '0, peak, trough;
  logic [7:0] period;
  int cycle = 0, n_assert = 0, n_fail = 0;
  exp_t sb[$];
  exp_t e;

  sine_period_monitor #(.PW(8)) dut (
    .clk(clk), .reset_n(reset_n), .d(d), .d_valid(d_valid), .period(period),
    .period_valid(period_valid), .locked(locked), .timeout(timeout),
    .peak(peak), .trough(trough)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp, input int tol = 0);
    n_assert++;
    assert (!$isunknown(obs) && obs >= exp - tol && obs <= exp + tol)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  function automatic int sine(input int k, input real a);
    real x;
    x = a * $sin(2.0 * 3.14159265358979 * k / 80.0);
    return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // event p (1-based) yields period pulse p-1; lock is certain from event 6, absent up to event 4
  function automatic int lk_of(input int p);
    return p <= 4 ? 0 : p == 5 ? -1 : 1;
  endfunction

  task automatic drive(input int x, input logic v = 1'b1);
    d = sample_t'(x);
    d_valid = v;
    @(negedge clk);
  endtask

  task automatic expect_pulse(input int per, input int lk, input int to, input int pk = 1000, input int tr = -1000);
    sb.push_back('{per, lk, to, pk, tr, cycle + 1});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(-1000, 1'b0);
    drive(-1000, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic sq_period(input bit emit, input int lk, input bit glitch = 1'b0, input bit gate = 1'b0);
    for (int i = 0; i < 100; i++) begin
      int x;
      x = i < 50 ? 1000 : -1000;
      if (glitch && (i % 50) >= 40) x = (i % 2) ? 100 : -100;
      if (i == 0 && emit) expect_pulse(100, lk, 0);
      drive(x);
      if (gate) drive((i % 2) ? 20000 : -20000, 1'b0);
    end
  endtask

  always @(negedge clk)
    if (reset_n === 1'b1 && period_valid === 1'b1) begin
      chk("pulse_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pulse_cycle", cycle, e.cyc);
        chk("period", period, e.per);
        if (e.lk >= 0) chk("locked", locked, e.lk);
        chk("timeout_at_pulse", timeout, e.to);
`ifdef SINE_MON_PEAK_EN
        chk("peak", peak, e.pk, 1);
        chk("trough", trough, e.tr, 1);
`else
        chk("peak_tied", peak, 0);
        chk("trough_tied", trough, 0);
`endif
      end
    end

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 200; k++) begin
      drive(sine(k, 12000.0));
      chk("reset_outputs", |{period, period_valid, locked, timeout, peak, trough}, 0);
    end
    // rising crossings land at k = 81, 161, 241; only the second and later report
    reset_n = 1'b1;
    for (int k = 0; k < 250; k++) begin
      if (k == 161 || k == 241) expect_pulse(80, 0, 0, 12000, -12000);
      drive(sine(k, 12000.0));
    end
    chk("sine_drained", sb.size(), 0);

    do_reset();
    repeat (50) drive(-1000);
    for (int p = 1; p <= 8; p++) sq_period(p > 1, lk_of(p));
    drive(-1000);
    chk("square_drained", sb.size(), 0);
    chk("square_no_timeout", timeout, 0);

    do_reset();
    repeat (50) drive(-1000);
    for (int p = 1; p <= 6; p++) sq_period(p > 1, lk_of(p), 1'b1);
    drive(-1000);
    chk("hyst_drained", sb.size(), 0);

    do_reset();
    repeat (50) drive(-1000);
    for (int p = 1; p <= 4; p++) sq_period(p > 1, lk_of(p), 1'b0, 1'b1);
    drive(-1000);
    chk("gate_drained", sb.size(), 0);

    do_reset();
    repeat (50) drive(-1000);
    for (int p = 1; p <= 6; p++) sq_period(p > 1, lk_of(p));
    expect_pulse(100, 1, 0);
    drive(2000);
    repeat (253) drive(2000);
    chk("timeout_early", timeout, 0);
    chk("locked_before_timeout", locked, 1);
    repeat (2) drive(2000);
    chk("timeout_set", timeout, 1);
    chk("timeout_unlock", locked, 0);
    chk("timeout_period_hold", period, 100);
    repeat (50) drive(-1000);
    sq_period(1'b0, 0);
    chk("timeout_sticky", timeout, 1);
    sq_period(1'b1, 0);
    drive(-1000);
    chk("timeout_cleared", timeout, 0);
    chk("timeout_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
